// File: rtl/otter_intr_pkg.sv
// ============================================================================
// Module      : otter_intr_pkg
// Description : Shared types and constants for the external interrupt block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package otter_intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PEND         = 2'd1,
    ST_HANDLER      = 2'd2,
    ST_HANDLER_PEND = 2'd3
  } intr_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] MCAUSE_EXT_INTR = 32'h8000_000B;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

endpackage

`default_nettype wire

// File: rtl/intr_sync.sv
// ============================================================================
// Module      : intr_sync
// Description : Two-flop synchronizer followed by a rising-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intr_sync (
  input  logic clk,
  input  logic RST_N,
  input  logic async_in,
  output logic edge_out
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic [1:0] r_warm;

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_warm  <= 2'd0;
    end else begin
      r_sync1 <= async_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_warm != 2'd3) begin
        r_warm <= r_warm + 2'd1;
      end
    end
  end

  // Edges only count once r_prev holds a real sample, so a line already
  // high at reset release is not mistaken for a new request.
  assign edge_out = r_sync2 & ~r_prev & (r_warm == 2'd3);

endmodule

`default_nettype wire

// File: rtl/intr_ctrl.sv
// ============================================================================
// Module      : intr_ctrl
// Description : Single-source external interrupt controller with M-mode CSRs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intr_ctrl
  import otter_intr_pkg::*;
(
  input  logic        clk,
  input  logic        RST_N,
  input  logic        irq_async,
  input  logic        instr_boundary,
  input  logic [31:0] pc_next,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        mret,
  output logic        INTR,
  output logic [31:0] csr_rdata,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic        irq_pending
);

  intr_state_e r_state;
  intr_state_e w_state_nxt;

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;

  logic        w_edge;
  logic        w_wr_mstatus;
  logic        w_wr_mtvec;
  logic        w_wr_mepc;
  logic        w_clr_mie;
  logic        w_take;

  intr_sync u_sync (
    .clk      (clk),
    .RST_N    (RST_N),
    .async_in (irq_async),
    .edge_out (w_edge)
  );

  assign w_wr_mstatus = csr_we && (csr_addr == CSR_MSTATUS);
  assign w_wr_mtvec   = csr_we && (csr_addr == CSR_MTVEC);
  assign w_wr_mepc    = csr_we && (csr_addr == CSR_MEPC);
  assign w_clr_mie    = w_wr_mstatus && !csr_wdata[MSTATUS_MIE_BIT];

  assign w_take = (r_state == ST_PEND) && r_mie && instr_boundary && !w_clr_mie;

  assign INTR        = RST_N && w_take;
  assign irq_pending = RST_N && ((r_state == ST_PEND) || (r_state == ST_HANDLER_PEND));

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_edge) w_state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (w_take) w_state_nxt = w_edge ? ST_HANDLER_PEND : ST_HANDLER;
      end
      ST_HANDLER: begin
        // A return coinciding with a new edge keeps the request alive.
        if (mret)        w_state_nxt = w_edge ? ST_PEND : ST_IDLE;
        else if (w_edge) w_state_nxt = ST_HANDLER_PEND;
      end
      ST_HANDLER_PEND: begin
        if (mret) w_state_nxt = ST_PEND;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      r_mie   <= 1'b0;
      r_mpie  <= 1'b0;
      r_mtvec <= 32'd0;
      r_mepc  <= 32'd0;
    end else begin
      if (w_take) begin
        r_mepc <= pc_next & 32'hFFFF_FFFC;
        r_mpie <= r_mie;
        r_mie  <= 1'b0;
      end else begin
        if (mret) begin
          r_mie  <= r_mpie;
          r_mpie <= 1'b1;
        end else if (w_wr_mstatus) begin
          r_mie  <= csr_wdata[MSTATUS_MIE_BIT];
          r_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
        end
        if (w_wr_mepc) begin
          r_mepc <= csr_wdata & 32'hFFFF_FFFC;
        end
      end
      if (w_wr_mtvec) begin
        r_mtvec <= csr_wdata & 32'hFFFF_FFFC;
      end
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE_BIT]  = r_mie;
        csr_rdata[MSTATUS_MPIE_BIT] = r_mpie;
      end
      CSR_MTVEC:  csr_rdata = r_mtvec;
      CSR_MEPC:   csr_rdata = r_mepc;
      CSR_MCAUSE: csr_rdata = MCAUSE_EXT_INTR;
      default:    csr_rdata = 32'd0;
    endcase
  end

  assign mtvec = r_mtvec;
  assign mepc  = r_mepc;

endmodule

`default_nettype wire

// File: tb/tb_intr_ctrl.sv
// ============================================================================
// Module      : tb_intr_ctrl
// Description : Scoreboard-driven self-checking bench for intr_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_intr_ctrl;
  import otter_intr_pkg::*;

  logic        clk;
  logic        RST_N;
  logic        irq_async;
  logic        instr_boundary;
  logic [31:0] pc_next;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        mret;
  logic        INTR;
  logic [31:0] csr_rdata;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        irq_pending;

  intr_ctrl dut (
    .clk            (clk),
    .RST_N          (RST_N),
    .irq_async      (irq_async),
    .instr_boundary (instr_boundary),
    .pc_next        (pc_next),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .mret           (mret),
    .INTR           (INTR),
    .csr_rdata      (csr_rdata),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .irq_pending    (irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {S_INTR, S_PEND, S_MTVEC, S_MEPC, S_RDATA} sig_e;
  typedef struct {
    sig_e        sel;
    logic [31:0] exp;
    string       tag;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_INTR:  return {31'd0, INTR};
      S_PEND:  return {31'd0, irq_pending};
      S_MTVEC: return mtvec;
      S_MEPC:  return mepc;
      S_RDATA: return csr_rdata;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input sig_e s, input logic [31:0] e, input string t);
    sb_t x;
    x.sel = s;
    x.exp = e;
    x.tag = t;
    sb_q.push_back(x);
  endtask

  task automatic drain();
    sb_t x;
    #1;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      chk(x.tag, observe(x.sel), x.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string t);
    csr_addr = a;
    push(S_RDATA, e, t);
    drain();
  endtask

  // Low for three cycles, then high long enough for the edge to land.
  task automatic irq_rise();
    irq_async = 1'b0;
    repeat (3) tick();
    irq_async = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; irq_async = 1'b0; instr_boundary = 1'b0; pc_next = 32'd0;
    csr_we = 1'b0; csr_addr = 12'd0; csr_wdata = 32'd0; mret = 1'b0;

    // Reset state
    tick(); tick();
    push(S_INTR, 32'd0, "rst_intr");
    push(S_PEND, 32'd0, "rst_pend");
    drain();
    RST_N = 1'b1;
    tick();
    push(S_MTVEC, 32'd0, "rst_mtvec");
    push(S_MEPC,  32'd0, "rst_mepc");
    drain();
    rd(CSR_MSTATUS, 32'd0, "rst_mstatus");
    repeat (3) tick();

    // CSR decode
    wr(CSR_MTVEC, 32'h0000_0103);
    rd(CSR_MTVEC, 32'h0000_0100, "mtvec_rd");
    push(S_MTVEC, 32'h0000_0100, "mtvec_port");
    drain();
    wr(CSR_MCAUSE, 32'd0);
    rd(CSR_MCAUSE, MCAUSE_EXT_INTR, "mcause_ro");
    rd(12'h123, 32'd0, "unmapped_rd");
    wr(CSR_MEPC, 32'h0000_0047);
    rd(CSR_MEPC, 32'h0000_0044, "mepc_wr");

    // Basic take with MIE=1, including edge latency
    wr(CSR_MSTATUS, 32'h0000_0008);
    rd(CSR_MSTATUS, 32'h0000_0008, "mstatus_mie");
    irq_async = 1'b1;
    tick(); tick();
    push(S_PEND, 32'd0, "lat_2edges");
    drain();
    tick();
    push(S_PEND, 32'd1, "lat_3edges");
    drain();
    pc_next = 32'h0000_0040;
    for (int i = 0; i < 4; i++) begin
      push(S_INTR, 32'd0, "no_bnd_intr");
      drain();
      tick();
    end
    instr_boundary = 1'b1;
    push(S_INTR, 32'd1, "take_intr");
    drain();
    tick();
    instr_boundary = 1'b0;
    push(S_INTR, 32'd0, "intr_one_cycle");
    push(S_PEND, 32'd0, "handler_pend0");
    push(S_MEPC, 32'h0000_0040, "take_mepc");
    drain();
    rd(CSR_MSTATUS, 32'h0000_0080, "take_mstatus");
    rd(CSR_MCAUSE, MCAUSE_EXT_INTR, "mcause_rd");

    // Edge during handler, then mret (beats a same-cycle mstatus write)
    irq_rise();
    push(S_PEND, 32'd1, "hpend_pend");
    instr_boundary = 1'b1;
    push(S_INTR, 32'd0, "hpend_no_intr");
    drain();
    instr_boundary = 1'b0;
    mret = 1'b1;
    csr_we = 1'b1; csr_addr = CSR_MSTATUS; csr_wdata = 32'd0;
    tick();
    mret = 1'b0;
    csr_we = 1'b0;
    rd(CSR_MSTATUS, 32'h0000_0088, "mret_prio");
    push(S_PEND, 32'd1, "mret_to_pend");
    drain();
    pc_next = 32'h0000_0080;
    instr_boundary = 1'b1;
    push(S_INTR, 32'd1, "pend_take2");
    drain();
    tick();
    instr_boundary = 1'b0;
    push(S_MEPC, 32'h0000_0080, "take2_mepc");
    push(S_PEND, 32'd0, "take2_pend");
    drain();

    // Boundary coinciding with an mstatus write that clears MIE
    mret = 1'b1;
    tick();
    mret = 1'b0;
    rd(CSR_MSTATUS, 32'h0000_0088, "mret_idle_mie");
    irq_rise();
    push(S_PEND, 32'd1, "pend_again");
    drain();
    instr_boundary = 1'b1;
    csr_we = 1'b1; csr_addr = CSR_MSTATUS; csr_wdata = 32'd0;
    push(S_INTR, 32'd0, "clr_mie_block");
    drain();
    tick();
    instr_boundary = 1'b0;
    csr_we = 1'b0;
    push(S_PEND, 32'd1, "clr_mie_pend");
    drain();
    rd(CSR_MSTATUS, 32'd0, "clr_mie_mstatus");

    // Masked pending request becomes takeable after enabling MIE
    instr_boundary = 1'b1;
    push(S_INTR, 32'd0, "mie0_bnd");
    drain();
    tick();
    instr_boundary = 1'b0;
    wr(CSR_MSTATUS, 32'h0000_0008);
    instr_boundary = 1'b1;
    push(S_INTR, 32'd1, "mie1_take");
    drain();
    tick();
    instr_boundary = 1'b0;

    // Edge arriving in the same cycle as take
    mret = 1'b1;
    tick();
    mret = 1'b0;
    irq_rise();
    irq_async = 1'b0;
    repeat (3) tick();
    irq_async = 1'b1;
    tick(); tick();
    instr_boundary = 1'b1;
    push(S_INTR, 32'd1, "edge_take_intr");
    drain();
    tick();
    instr_boundary = 1'b0;
    push(S_PEND, 32'd1, "edge_take_hpend");
    drain();

    // Reset while in HANDLER_PEND, with irq_async held high
    RST_N = 1'b0;
    push(S_INTR, 32'd0, "rst2_intr");
    push(S_PEND, 32'd0, "rst2_pend");
    drain();
    tick();
    RST_N = 1'b1;
    push(S_PEND, 32'd0, "rst2_pend_after");
    push(S_MEPC, 32'd0, "rst2_mepc");
    push(S_MTVEC, 32'd0, "rst2_mtvec");
    drain();
    rd(CSR_MSTATUS, 32'd0, "rst2_mstatus");
    repeat (5) tick();
    push(S_PEND, 32'd0, "no_edge_at_release");
    drain();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    push(S_PEND, 32'd0, "mret_idle_hold");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
